wbu_result_arb: RTL and testbench
=================================

// Module: wbu_result_arb
// PURPOSE
//  Writeback arbiter directly downstream of exu. Collects results from NUM_SRC execution
//  pipes (4 ALU + 1 MUL), buffers each in a per-source FIFO, and forwards up to NUM_WB
//  results per cycle to the register-file write ports and ROB completion bus.
//  Round-robin fairness across sources; per-source backpressure via src_ready.
// PARAMETERS
//  NUM_SRC   5   execution pipes feeding the arbiter
//  NUM_WB    2   writeback ports per cycle (1..NUM_SRC)
//  DEPTH     4   entries per source FIFO (power of 2, >=2)
//  PREG_W    6   physical register index width
//  ROB_W     5   ROB id width
// PORTS
//  clk          in   1                 clock
//  rst_n        in   1                 async active-low reset
//  flush        in   1                 pipeline flush (mispredict/exception)
//  src_valid    in   NUM_SRC           result valid per pipe
//  src_ready    out  NUM_SRC           FIFO can accept this cycle
//  src_wen      in   NUM_SRC           result writes a register
//  src_preg     in   NUM_SRC x PREG_W  destination preg
//  src_rob_id   in   NUM_SRC x ROB_W   ROB entry completed
//  src_data     in   NUM_SRC x 32      result value
//  wb_valid     out  NUM_WB            registered writeback valid
//  wb_wen       out  NUM_WB            regfile write enable (0 if src_wen=0 or preg=0)
//  wb_preg      out  NUM_WB x PREG_W
//  wb_rob_id    out  NUM_WB x ROB_W
//  wb_data      out  NUM_WB x 32
// BEHAVIOUR
//  - Reset: all FIFOs empty, rr_ptr=0, wb_valid/wb_wen=0, wb_preg/rob_id/data=0.
//  - Accept: push when src_valid & src_ready; src_ready = (count<DEPTH), from state only;
//    a full FIFO rejects even if popped same cycle.
//  - Arbitration (per cycle): candidates = heads of non-empty FIFOs (max 1 per source).
//    Scan sources from rr_ptr upward modulo NUM_SRC; grant first NUM_WB candidates,
//    slot 0 = first found. Granted heads pop this cycle.
//  - rr_ptr <= (last granted index + 1) mod NUM_SRC; unchanged if nothing granted.
//  - Output: granted entries registered into wb_* next edge; unfilled slots wb_valid=0.
//    Latency src accept -> wb_valid: 2 cycles (push edge, then grant/register edge).
//  - wb_wen = src_wen & (preg!=0); entry still reported on wb_valid for ROB completion.
//  - Simultaneous push+pop on non-full FIFO: both happen, count unchanged.
//  - Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  - flush: takes priority; at next edge all FIFOs empty, wb_valid=0, rr_ptr=0;
//    inputs presented during flush cycle are dropped (src_ready still as computed).
//  - Async reset mid-operation: immediate return to reset state, buffered results lost.
// CONFIGURATION
//  WBU_BYPASS_EN defined: a source whose FIFO is empty may be granted in the cycle its
//    result arrives (input presented as head candidate, not pushed if granted);
//    latency 1 cycle. Ordering within a source preserved (bypass only when empty).
//  WBU_BYPASS_EN undefined: all results pass through FIFO; latency fixed at 2.
// STRUCTURE
//  - Package wbu_pkg: wb_entry_t struct {wen, preg, rob_id, data}, PREG_W/ROB_W
//    defaults, rr helper function next_rr(idx, n).
//  - Sub-module wbu_src_fifo (one per source, generate loop): push/pop/flush, head,
//    count, full/empty. Arbiter, rr_ptr and output registers in top.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> wb_valid=0, all src_ready=1, rr_ptr=0 immediately.
//  2 Single: src2 valid, preg=7, data=0xDEADBEEF at t0 -> wb_valid[0]=1, preg 7,
//    data 0xDEADBEEF at t0+2 (t0+1 with WBU_BYPASS_EN); wb_valid[1]=0.
//  3 Fairness: all 5 sources valid every cycle -> grants (0,1),(2,3),(4,0),(1,2)...;
//    no source starves; each emits exactly 2 results per 5 cycles.
//  4 Backpressure: src0 valid 6 back-to-back, wb ports saturated by srcs 1-4 ->
//    src_ready[0]=0 after 4 accepted; no result lost or duplicated; per-source order kept.
//  5 r0 write: src_wen=1, preg=0 -> wb_valid=1, wb_wen=0, rob_id passed through.
//  6 Flush with 3 entries buffered + new input -> next cycle wb_valid=0, FIFOs empty,
//    none of the flushed results ever appear on wb_*.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared types and helpers for the writeback result arbiter.
//   wb_entry_t : one buffered execution result (wen, preg, rob_id, data)
//   next_rr    : round-robin successor of a source index, wrapping at n
package wbu_pkg;

    localparam int PREG_W_DEF = 6;
    localparam int ROB_W_DEF  = 5;

    typedef struct packed {
        logic                  wen;
        logic [PREG_W_DEF-1:0] preg;
        logic [ROB_W_DEF-1:0]  rob_id;
        logic [31:0]           data;
    } wb_entry_t;

    function automatic int next_rr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wbu_src_fifo.sv
// Per-source result FIFO for the writeback arbiter.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           empties the FIFO at the next edge (wins over push/pop)
//   push, din       write an entry (ignored when full, even if popped same cycle)
//   pop             drop the head entry (ignored when empty)
//   head            oldest entry (undefined content when empty)
//   full, empty     occupancy flags derived from the registered count
module wbu_src_fifo
    import wbu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries below count are ever read out.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wbu_result_arb.sv
// Writeback result arbiter: buffers results from NUM_SRC execution pipes in
// per-source FIFOs and forwards up to NUM_WB per cycle, round-robin, to the
// regfile write ports and ROB completion bus.
// Ports:
//   clk, rst_n, flush                      clock, async active-low reset, flush
//   src_valid/src_ready                    per-pipe handshake (ready = FIFO not full)
//   src_wen/src_preg/src_rob_id/src_data   per-pipe result payload
//   wb_valid/wb_wen/wb_preg/wb_rob_id/wb_data  registered writeback slots
// Build option:
//   WBU_BYPASS_EN  an empty source may be granted straight from its input in
//                  the arrival cycle (latency 1 instead of 2).
module wbu_result_arb
    import wbu_pkg::*;
#(
    parameter int NUM_SRC = 5,
    parameter int NUM_WB  = 2,
    parameter int DEPTH   = 4,
    parameter int PREG_W  = PREG_W_DEF,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC-1:0]             src_wen,
    input  logic [NUM_SRC-1:0][PREG_W-1:0] src_preg,
    input  logic [NUM_SRC-1:0][ROB_W-1:0]  src_rob_id,
    input  logic [NUM_SRC-1:0][31:0]       src_data,
    output logic [NUM_WB-1:0]              wb_valid,
    output logic [NUM_WB-1:0]              wb_wen,
    output logic [NUM_WB-1:0][PREG_W-1:0]  wb_preg,
    output logic [NUM_WB-1:0][ROB_W-1:0]   wb_rob_id,
    output logic [NUM_WB-1:0][31:0]        wb_data
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int WB_W  = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    wb_entry_t          in_entry   [NUM_SRC];
    wb_entry_t          head       [NUM_SRC];
    wb_entry_t          cand_entry [NUM_SRC];
    wb_entry_t          slot_entry [NUM_WB];
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_WB-1:0]  slot_valid;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   rr_next;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign in_entry[i] = '{wen:    src_wen[i],
                               preg:   src_preg[i],
                               rob_id: src_rob_id[i],
                               data:   src_data[i]};
        assign src_ready[i] = ~full[i];

        wbu_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (in_entry[i]),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    always_comb begin
        int idx;
        int n;
        int last;
        idx        = 0;
        n          = 0;
        last       = 0;
        grant      = '0;
        slot_valid = '0;
        push       = '0;
        pop        = '0;
        rr_next    = rr_ptr;
        for (int j = 0; j < NUM_WB; j++) slot_entry[j] = '0;

        for (int s = 0; s < NUM_SRC; s++) begin
`ifdef WBU_BYPASS_EN
            // Bypass only from an empty FIFO so per-source order is kept.
            cand[s]       = ~empty[s] | src_valid[s];
            cand_entry[s] = empty[s] ? in_entry[s] : head[s];
`else
            cand[s]       = ~empty[s];
            cand_entry[s] = head[s];
`endif
        end

        // Rotate the scan start to rr_ptr; first NUM_WB candidates win, in order.
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (cand[idx[SRC_W-1:0]] && n < NUM_WB) begin
                slot_entry[n[WB_W-1:0]] = cand_entry[idx[SRC_W-1:0]];
                slot_valid[n[WB_W-1:0]] = 1'b1;
                grant[idx[SRC_W-1:0]]   = 1'b1;
                last = idx;
                n    = n + 1;
            end
        end
        if (n > 0) rr_next = SRC_W'(next_rr(last, NUM_SRC));

        for (int s = 0; s < NUM_SRC; s++) begin
            pop[s]  = grant[s] & ~empty[s];
            push[s] = src_valid[s] & ~full[s] & ~flush;
`ifdef WBU_BYPASS_EN
            if (grant[s] && empty[s]) push[s] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            wb_valid  <= '0;
            wb_wen    <= '0;
            wb_preg   <= '0;
            wb_rob_id <= '0;
            wb_data   <= '0;
        end else if (flush) begin
            rr_ptr    <= '0;
            wb_valid  <= '0;
            wb_wen    <= '0;
            wb_preg   <= '0;
            wb_rob_id <= '0;
            wb_data   <= '0;
        end else begin
            rr_ptr <= rr_next;
            for (int j = 0; j < NUM_WB; j++) begin
                wb_valid[j]  <= slot_valid[j];
                // A write to p0 still completes in the ROB but never touches the regfile.
                wb_wen[j]    <= slot_entry[j].wen & (slot_entry[j].preg != '0);
                wb_preg[j]   <= slot_entry[j].preg;
                wb_rob_id[j] <= slot_entry[j].rob_id;
                wb_data[j]   <= slot_entry[j].data;
            end
        end
    end

endmodule

// File: tb/tb_wbu_result_arb.sv
`timescale 1ns/1ps
module tb_wbu_result_arb;
    import wbu_pkg::*;

    localparam int NS    = 5;
    localparam int NW    = 2;
    localparam int DEPTH = 4;
`ifdef WBU_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic [NS-1:0]        src_valid;
    logic [NS-1:0]        src_ready;
    logic [NS-1:0]        src_wen;
    logic [NS-1:0][5:0]   src_preg;
    logic [NS-1:0][4:0]   src_rob_id;
    logic [NS-1:0][31:0]  src_data;
    logic [NW-1:0]        wb_valid;
    logic [NW-1:0]        wb_wen;
    logic [NW-1:0][5:0]   wb_preg;
    logic [NW-1:0][4:0]   wb_rob_id;
    logic [NW-1:0][31:0]  wb_data;

    always #5 clk = ~clk;

    wbu_result_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_wen    (src_wen),
        .src_preg   (src_preg),
        .src_rob_id (src_rob_id),
        .src_data   (src_data),
        .wb_valid   (wb_valid),
        .wb_wen     (wb_wen),
        .wb_preg    (wb_preg),
        .wb_rob_id  (wb_rob_id),
        .wb_data    (wb_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per source, a round-robin start index and
    // the slots that must appear on wb_* after the edge.
    wb_entry_t     mq [NS][$];
    int            m_rr;
    logic [NW-1:0] e_valid;
    wb_entry_t     e_slot [NW];
    logic [NS-1:0] last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wb_entry_t in_of(input int s);
        return '{wen: src_wen[s], preg: src_preg[s], rob_id: src_rob_id[s], data: src_data[s]};
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NS; s++) mq[s].delete();
        m_rr    = 0;
        e_valid = '0;
    endtask

    task automatic model_step();
        logic [NS-1:0] rdy;
        logic [NS-1:0] byp;
        int n;
        int last;
        for (int s = 0; s < NS; s++) rdy[s] = (mq[s].size() < DEPTH);
        e_valid = '0;
        byp     = '0;
        if (flush) begin
            model_clear();
            return;
        end
        n    = 0;
        last = -1;
        for (int k = 0; k < NS; k++) begin
            int s;
            s = (m_rr + k) % NS;
            if (n < NW) begin
                if (mq[s].size() > 0) begin
                    e_slot[n]  = mq[s].pop_front();
                    e_valid[n] = 1'b1;
                    n++;
                    last = s;
                end else if (BYP && src_valid[s]) begin
                    e_slot[n]  = in_of(s);
                    e_valid[n] = 1'b1;
                    byp[s]     = 1'b1;
                    n++;
                    last = s;
                end
            end
        end
        for (int s = 0; s < NS; s++)
            if (src_valid[s] && rdy[s] && !byp[s]) mq[s].push_back(in_of(s));
        if (last >= 0) m_rr = (last + 1) % NS;
    endtask

    // One clock: check ready mid-cycle, advance model at the edge, compare after it.
    task automatic cycle();
        logic [NS-1:0] exp_rdy;
        @(negedge clk);
        for (int s = 0; s < NS; s++) exp_rdy[s] = (mq[s].size() < DEPTH);
        chk("src_ready", src_ready, exp_rdy);
        last_ready = src_ready;
        @(posedge clk);
        model_step();
        #1;
        for (int j = 0; j < NW; j++) begin
            chk("wb_valid", wb_valid[j], e_valid[j]);
            if (e_valid[j]) begin
                chk("wb_wen", wb_wen[j], e_slot[j].wen && (e_slot[j].preg != 0));
                chk("wb_preg", wb_preg[j], e_slot[j].preg);
                chk("wb_rob_id", wb_rob_id[j], e_slot[j].rob_id);
                chk("wb_data", wb_data[j], e_slot[j].data);
            end
        end
    endtask

    task automatic do_reset();
        src_valid = '0;
        flush     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wb_valid", wb_valid, 0);
        chk("async_rst_src_ready", src_ready, 5'h1f);
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic set_src(input int s, input logic wen, input logic [5:0] preg,
                           input logic [4:0] rob, input logic [31:0] data);
        src_valid[s]  = 1'b1;
        src_wen[s]    = wen;
        src_preg[s]   = preg;
        src_rob_id[s] = rob;
        src_data[s]   = data;
    endtask

    initial begin
        int cnt [NS];
        int acc;
        int next0;
        bit low_seen;

        rst_n = 1'b0; flush = 1'b0;
        src_valid = '0; src_wen = '0; src_preg = '0; src_rob_id = '0; src_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_wb_wen", wb_wen, 0);
        chk("reset_src_ready", src_ready, 5'h1f);
        chk("reset_wb_data", wb_data, 0);
        chk("reset_wb_preg", wb_preg, 0);
        rst_n = 1'b1;

        // Single result from src2
        set_src(2, 1'b1, 6'd7, 5'd3, 32'hDEADBEEF);
        for (int c = 1; c <= 3; c++) begin
            cycle();
            src_valid = '0;
            if (c == LAT) begin
                chk("single_valid", wb_valid, 2'b01);
                chk("single_preg", wb_preg[0], 7);
                chk("single_data", wb_data[0], 32'hDEADBEEF);
                chk("single_wen", wb_wen[0], 1);
            end else begin
                chk("single_idle", wb_valid, 0);
            end
        end

        // Write to p0: completes but must not write the regfile
        set_src(1, 1'b1, 6'd0, 5'd9, 32'h55);
        for (int c = 1; c <= 3; c++) begin
            cycle();
            src_valid = '0;
            if (c == LAT) begin
                chk("r0_valid", wb_valid, 2'b01);
                chk("r0_wen", wb_wen[0], 0);
                chk("r0_rob_id", wb_rob_id[0], 9);
            end
        end

        // Fairness: every source valid every cycle, rob_id tags the source
        do_reset();
        for (int s = 0; s < NS; s++) cnt[s] = 0;
        for (int c = 1; c <= LAT + 9; c++) begin
            for (int s = 0; s < NS; s++)
                set_src(s, 1'b1, 6'($urandom_range(1, 63)), 5'(s), $urandom);
            cycle();
            if (c >= LAT) begin
                chk("fair_both_valid", wb_valid, 2'b11);
                if (c - LAT < 5) begin
                    chk("fair_slot0_src", wb_rob_id[0], (2 * (c - LAT)) % NS);
                    chk("fair_slot1_src", wb_rob_id[1], (2 * (c - LAT) + 1) % NS);
                end
                for (int j = 0; j < NW; j++)
                    if (wb_rob_id[j] < NS) cnt[wb_rob_id[j]]++;
            end
        end
        for (int s = 0; s < NS; s++) chk("fair_count_per_10", cnt[s], 4);

        // Backpressure on src0 while srcs 1-4 saturate the ports
        do_reset();
        acc = 0; next0 = 0; low_seen = 0;
        for (int c = 0; c < 45; c++) begin
            src_valid = '0;
            if (c < 20) begin
                for (int s = 1; s < NS; s++)
                    set_src(s, $urandom_range(0, 1), 6'($urandom), 5'($urandom), {8'(s), 24'($urandom)});
            end
            if (c < 15) set_src(0, 1'b1, 6'(acc + 1), 5'(acc), {8'd0, 24'(acc)});
            cycle();
            if (src_valid[0] && last_ready[0]) acc++;
            if (c < 15 && !last_ready[0]) low_seen = 1'b1;
            for (int j = 0; j < NW; j++) begin
                if (wb_valid[j] && wb_data[j][31:24] == 8'd0) begin
                    chk("bp_src0_order", wb_data[j][23:0], next0);
                    next0++;
                end
            end
        end
        chk("bp_ready_low_seen", low_seen, 1);
        chk("bp_src0_out_count", next0, acc);

        // Flush with buffered entries plus a new input
        do_reset();
        for (int s = 0; s < 3; s++) set_src(s, 1'b1, 6'(s + 10), 5'(s), 32'hF00D_0000 + s);
        cycle();
        src_valid = '0;
        flush = 1'b1;
        set_src(4, 1'b1, 6'd20, 5'd4, 32'hF00D_0004);
        cycle();
        chk("flush_wb_valid", wb_valid, 0);
        chk("flush_src_ready", src_ready, 5'h1f);
        flush = 1'b0;
        src_valid = '0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("flush_no_leak", wb_valid, 0);
        end

        // Random traffic with occasional flushes and one mid-traffic reset
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) do_reset();
            flush = ($urandom_range(0, 39) == 0);
            src_valid = '0;
            for (int s = 0; s < NS; s++) begin
                if ($urandom_range(0, 99) < 55)
                    set_src(s, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom),
                            5'($urandom), $urandom);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
